mem_arbiter: RTL and testbench

// - Shares the single-port 16-bit word memory between an instruction-fetch (I) port and a data (D) port.
// - Serialises requests, holds each access for LAT cycles to model slow memory, returns read data with a done pulse.
// - Sits between fetch/mem stages and memory2c; sole driver of its enable/wr/addr/data_in/createdump.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow 16-bit word memory between an I-fetch port and a D port.
// Define MEM_ARB_RR_EN for round-robin arbitration in place of D priority with starvation relief.
module mem_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_i,
  input  logic [15:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_done_o,
  output logic [15:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_wr_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_done_o,
  output logic [15:0] d_rdata_o,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        createdump_i,
  output logic        mem_dump_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q;
  logic        port_q, wr_q, pend_q, pend_d, sched_dump, start, pick_d;
  logic        i_gnt_q, i_done_q, d_gnt_q, d_done_q, mem_en_q, mem_wr_q, mem_dump_q;
  logic [15:0] i_rdata_q, d_rdata_q, mem_addr_q, mem_wdata_q, wdata_q;
  logic [3:0]  cnt_q;
`ifdef MEM_ARB_RR_EN
  logic        last_d_q;
  assign pick_d = d_req_i & (~i_req_i | ~last_d_q);
`else
  logic [3:0]  starve_q;
  assign pick_d = d_req_i & ~(i_req_i & (starve_q == 4'(STARVE_MAX)));
`endif
  assign pend_d     = pend_q | createdump_i;
  // a dump is scheduled for the next IDLE cycle and blocks any access from starting there
  assign sched_dump = ~mem_dump_q & pend_d & (state_q == IDLE || state_q == DONE);
  assign start      = (state_q == IDLE) & (i_req_i | d_req_i) & ~mem_dump_q & ~sched_dump;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      wr_q        <= 1'b0;
      pend_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      i_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_dump_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      mem_dump_q <= sched_dump;
      pend_q     <= mem_dump_q ? createdump_i : pend_d;
      case (state_q)
        IDLE: begin
`ifndef MEM_ARB_RR_EN
          if (!i_req_i) starve_q <= '0;
`endif
          if (start) begin
            state_q     <= ACCESS;
            port_q      <= pick_d;
            wr_q        <= pick_d & d_wr_i;
            wdata_q     <= d_wdata_i;
            cnt_q       <= 4'(LAT - 1);
            i_gnt_q     <= ~pick_d;
            d_gnt_q     <= pick_d;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= pick_d ? d_addr_i : i_addr_i;
            mem_wr_q    <= (LAT == 1) & pick_d & d_wr_i;
            mem_wdata_q <= ((LAT == 1) & pick_d & d_wr_i) ? d_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= pick_d;
`else
            starve_q    <= (pick_d & i_req_i) ? starve_q + 4'd1 : '0;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q     <= DONE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= ~port_q;
            d_done_q    <= port_q;
            if (!wr_q && port_q) d_rdata_q <= mem_rdata_i;
            if (!wr_q && !port_q) i_rdata_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            // the single memory write lands in the final busy cycle
            if (cnt_q == 4'd1 && wr_q) begin
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= wdata_q;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign i_gnt_o     = i_gnt_q;
  assign i_done_o    = i_done_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_dump_o  = mem_dump_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters with LAT = 1, 2, 3, each on its own word memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] i_req = '0, d_req = '0, d_wr = '0, createdump = '0;
  logic [2:0][15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] i_gnt, i_done, d_gnt, d_done, mem_en, mem_wr, mem_dump, busy;
  logic [2:0][15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [15:0] mem [256];
    int writes = 0;
    initial begin
      for (int a = 0; a < 256; a++) mem[a] = 16'h0;
      mem[8'h10] = 16'hBEEF;
      mem[8'h11] = 16'hCAFE;
    end
    always @(posedge clk)
      if (mem_en[g] && mem_wr[g]) begin
        mem[mem_addr[g][7:0]] = mem_wdata[g];
        writes++;
      end
    mem_arbiter #(.LAT(g + 1), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_i(i_req[g]), .i_addr_i(i_addr[g]), .i_gnt_o(i_gnt[g]), .i_done_o(i_done[g]), .i_rdata_o(i_rdata[g]),
      .d_req_i(d_req[g]), .d_wr_i(d_wr[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_gnt_o(d_gnt[g]), .d_done_o(d_done[g]), .d_rdata_o(d_rdata[g]),
      .mem_en_o(mem_en[g]), .mem_wr_o(mem_wr[g]), .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem[mem_addr[g][7:0]]), .createdump_i(createdump[g]), .mem_dump_o(mem_dump[g]), .busy_o(busy[g])
    );
  end
  typedef struct {
    int k;
    logic ir, dr, dw, cd;
    logic [15:0] ia, da, dwd;
    logic [7:0] e;
    logic [15:0] eri, erd;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(int k, int ir, int ia, int dr, int dw, int da, int dwd, int cd, int e, int eri, int erd);
    vec_t r;
    r.k = k; r.ir = ir[0]; r.ia = 16'(ia); r.dr = dr[0]; r.dw = dw[0]; r.da = 16'(da);
    r.dwd = 16'(dwd); r.cd = cd[0]; r.e = 8'(e); r.eri = 16'(eri); r.erd = 16'(erd);
    return r;
  endfunction
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int t;
    logic seen;
    logic exp_d;
    // expected bits: {i_gnt, i_done, d_gnt, d_done, mem_en, mem_wr, mem_dump, busy}
    // LAT=1 I read of 0x0010
    tv.push_back(v(0, 1, 'h10, 0, 0, 0, 0, 0, 'b0000_0000, 0, 0));
    tv.push_back(v(0, 1, 'h10, 0, 0, 0, 0, 0, 'b1000_1001, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b0100_0001, 'hBEEF, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 'b0000_0000, 'hBEEF, 0));
    // LAT=3 D write 0x1234 to 0x0020, then read it back
    tv.push_back(v(2, 0, 0, 1, 1, 'h20, 'h1234, 0, 'b0000_0000, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 1, 'h20, 'h1234, 0, 'b0010_1001, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 1, 'h20, 'h1234, 0, 'b0000_1001, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 1, 'h20, 'h1234, 0, 'b0000_1101, 0, 0));
    tv.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 'b0001_0001, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 0, 'h20, 0, 0, 'b0000_0000, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 0, 'h20, 0, 0, 'b0010_1001, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 0, 'h20, 0, 0, 'b0000_1001, 0, 0));
    tv.push_back(v(2, 0, 0, 1, 0, 'h20, 0, 0, 'b0000_1001, 0, 0));
    tv.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 'b0001_0001, 0, 'h1234));
    tv.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 'b0000_0000, 0, 'h1234));
    // LAT=2 createdump during ACCESS, I request waiting behind the dump cycle
    tv.push_back(v(1, 0, 0, 1, 0, 'h10, 0, 0, 'b0000_0000, 0, 0));
    tv.push_back(v(1, 0, 0, 1, 0, 'h10, 0, 1, 'b0010_1001, 0, 0));
    tv.push_back(v(1, 1, 'h11, 1, 0, 'h10, 0, 0, 'b0000_1001, 0, 0));
    tv.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 0, 'b0001_0001, 0, 'hBEEF));
    tv.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 0, 'b0000_0010, 0, 'hBEEF));
    tv.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 0, 'b0000_0000, 0, 'hBEEF));
    tv.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 0, 'b1000_1001, 0, 'hBEEF));
    tv.push_back(v(1, 1, 'h11, 0, 0, 0, 0, 0, 'b0000_1001, 0, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0100_0001, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0000_0000, 'hCAFE, 'hBEEF));
    // LAT=2 d_req dropped after grant: done still pulses, nothing restarts
    tv.push_back(v(1, 0, 0, 1, 0, 'h10, 0, 0, 'b0000_0000, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0010_1001, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0000_1001, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0001_0001, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0000_0000, 'hCAFE, 'hBEEF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 'b0000_0000, 'hCAFE, 'hBEEF));
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_outputs%0d", k),
            {i_gnt[k], i_done[k], d_gnt[k], d_done[k], mem_en[k], mem_wr[k], mem_dump[k], busy[k],
             i_rdata[k], d_rdata[k], mem_addr[k]}, '0);
    rst_n = 1'b1;
    foreach (tv[n]) begin
      int k;
      @(negedge clk);
      k = tv[n].k;
      check($sformatf("vec%0d", n),
            {i_gnt[k], i_done[k], d_gnt[k], d_done[k], mem_en[k], mem_wr[k], mem_dump[k], busy[k], i_rdata[k], d_rdata[k]},
            {tv[n].e, tv[n].eri, tv[n].erd});
      i_req[k] = tv[n].ir; i_addr[k] = tv[n].ia; d_req[k] = tv[n].dr; d_wr[k] = tv[n].dw;
      d_addr[k] = tv[n].da; d_wdata[k] = tv[n].dwd; createdump[k] = tv[n].cd;
    end
    check("single_write_count", 64'(gen_dut[2].writes), 64'd1);
    check("written_word", 64'(gen_dut[2].mem[8'h20]), 64'h1234);
    // both ports held high on the LAT=1 arbiter: grant order
    i_req[0] = 1'b1; i_addr[0] = 16'h10; d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h11;
    for (int n = 0; n < 10; n++) begin
      t = 0;
      @(negedge clk);
      while (!(i_gnt[0] || d_gnt[0]) && t < 20) begin
        @(negedge clk);
        t++;
      end
`ifdef MEM_ARB_RR_EN
      exp_d = (n % 2) == 0;
`else
      exp_d = (n % 5) != 4;
`endif
      check($sformatf("grant_order%0d(1=D,2=timeout)", n), (t >= 20) ? 64'd2 : 64'(d_gnt[0]), 64'(exp_d));
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    t = 0;
    while (busy[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_idle", {busy[0], mem_en[0]}, '0);
    // reset during a LAT=3 D write with cnt>0
    d_req[2] = 1'b1; d_wr[2] = 1'b1; d_addr[2] = 16'h30; d_wdata[2] = 16'h5555;
    @(negedge clk);
    check("rst_pre_access", {d_gnt[2], mem_en[2], mem_wr[2]}, 3'b110);
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", {mem_en[2], busy[2], mem_wr[2], d_gnt[2]}, '0);
    d_req[2] = 1'b0; d_wr[2] = 1'b0;
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= d_done[2] | d_gnt[2] | mem_en[2];
    end
    check("rst_no_done", 64'(seen), 64'd0);
    check("rst_no_write", 64'(gen_dut[2].writes), 64'd1);
    check("rst_mem_unchanged", 64'(gen_dut[2].mem[8'h30]), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
